t_ff_counter: RTL and testbench
===============================

Name: t_ff_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop.
- Holds a WIDTH-bit register built from per-bit toggle cells. The register can be bit-masked toggled, counted up or down modulo MAX_VAL+1 (wrap or saturate), loaded, or held.
- Used as a general-purpose toggle register and event/divider counter in the practice designs.
- Provides range flags, a registered wrap pulse and a registered error pulse.

Parameters:
- WIDTH, 8: register width in bits (≥1).
- MAX_VAL, 2**WIDTH-1: largest legal value. Counting is modulo MAX_VAL+1. Must be < 2**WIDTH.
- RST_VAL, 0: value loaded into q on reset. Must be ≤ MAX_VAL.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, synchronous, active-low.
- en, input, 1: operation enable for the mode function.
- mode, input, 2: 00 HOLD, 01 TOGGLE, 10 UP, 11 DOWN.
- tmask, input, WIDTH: per-bit toggle enables, used in TOGGLE mode.
- load, input, 1: synchronous load of din.
- din, input, WIDTH: load value.
- q, output, WIDTH: registered value.
- at_max, output, 1: combinational, q == MAX_VAL.
- at_min, output, 1: combinational, q == 0.
- wrap, output, 1: registered 1-cycle pulse, q wrapped on the previous edge.
- err, output, 1: registered 1-cycle pulse, the previous edge rejected an illegal value.

Behaviour:
- Reset: on a rising clk edge with rst=0: q=RST_VAL, wrap=0, err=0.
- All updates occur on the rising clk edge. wrap and err are cleared every cycle unless set by that edge's event.
- Priority: reset > load > (en & mode) > hold.
- load=1:
  - If din ≤ MAX_VAL, q=din.
  - Otherwise q holds and err=1.
  - en and mode are ignored that cycle.
- en=0 with no load: q holds.
- HOLD (mode 00): q holds.
- TOGGLE (mode 01): next = q ^ tmask.
  - If next ≤ MAX_VAL, q=next.
  - Otherwise q holds and err=1.
  - tmask=0 holds q with no error.
  - TOGGLE never asserts wrap.
- UP (mode 10):
  - If q < MAX_VAL, q=q+1.
  - At q==MAX_VAL: with SATURATE=0, q=0 and wrap=1. With SATURATE=1, q holds and wrap=0.
- DOWN (mode 11):
  - If q > 0, q=q-1.
  - At q==0: with SATURATE=0, q=MAX_VAL and wrap=1. With SATURATE=1, q holds.
- Latency: q reflects the operation one edge after the inputs are sampled. wrap and err appear in the same cycle as the updated q.
- Arithmetic: compare and increment/decrement in WIDTH+1 bits. No carry or borrow leaks into q.
- Internal structure:
  - Each bit is a toggle cell.
  - Top-level logic computes the per-bit toggle vector t_vec = q ^ next_q for every case.
  - Load and reset are applied through the cells' own inputs.
- Reset mid-operation: discards any pending op, and wrap/err are forced low that edge. The first operation is accepted on the edge after rst returns high.
- With MAX_VAL == 2**WIDTH-1, err can only come from TOGGLE or load when the values exceed range, and it never asserts.

Decomposition:
- Package t_ff_pkg holds:
  - mode constants MODE_HOLD, MODE_TOGGLE, MODE_UP, MODE_DOWN (2-bit);
  - the width of the mode field.
- Sub-module t_cell: single-bit T flip-flop with ports clk, rst (sync active-low), t, ld, d, rst_val, q.
  - ld overrides t.
  - Instantiated WIDTH times via generate.
- Top level holds the next-value, range-check, wrap and err logic.

Test Plan (WIDTH=4, MAX_VAL=9, RST_VAL=3 unless stated):
1. Reset and hold: rst=0 for 2 edges, then rst=1, en=0 for 3 edges. Expect q=3, at_min=0, at_max=0, wrap=0, err=0 throughout.
2. Up wrap (SATURATE=0): load din=8, then en=1, mode=UP for 3 edges. Expect q=9 (at_max=1), then q=0 with wrap=1 for exactly one cycle, then q=1 with wrap=0.
3. Down saturate (SATURATE=1): load 1, then DOWN for 3 edges. Expect q=0, 0, 0 with at_min=1 and wrap never asserted.
4. Toggle and range reject: q=3, then TOGGLE with tmask=0101 gives q=6. Then tmask=1000 would give 14 > 9, so q stays 6 and err=1 for one cycle.
5. Load priority and illegal load: load=1, din=12, en=1, mode=UP. Expect q unchanged, err=1. Then load=1, din=7 gives q=7, err=0.
6. Reset mid-count: counting UP at q=9 with rst=0 on the wrap edge. Expect q=3, wrap=0. Then rst=1, UP gives q=4.

Source files
------------

// File: rtl/t_ff_pkg.sv
// rtl/t_ff_pkg.sv - shared mode encoding for the toggle-cell counter
package t_ff_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_TOGGLE = 2'b01;
  localparam mode_t MODE_UP     = 2'b10;
  localparam mode_t MODE_DOWN   = 2'b11;

endpackage

// File: rtl/t_cell.sv
// rtl/t_cell.sv - single-bit toggle flip-flop with synchronous load and reset
module t_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= rst_val;
    end else if (ld) begin
      r_q <= d;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/t_ff_counter.sv
// rtl/t_ff_counter.sv - WIDTH-bit toggle/up/down/load register built from t_cell bits
module t_ff_counter
  import t_ff_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned RST_VAL  = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  tmask,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  q,
  output logic              at_max,
  output logic              at_min,
  output logic              wrap,
  output logic              err
);

  localparam logic [WIDTH:0]   LP_MAX = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   LP_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RST_VAL);

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_din_ext;
  logic [WIDTH:0]   w_tog_ext;
  logic [WIDTH:0]   w_next_ext;
  logic [WIDTH-1:0] w_t_vec;
  logic             w_ld;
  logic             w_wrap_set;
  logic             w_err_set;
  logic             w_unused;

  logic r_wrap;
  logic r_err;

  // All range checks run one bit wider so no carry/borrow can alias into q.
  assign w_q_ext   = {1'b0, q};
  assign w_din_ext = {1'b0, din};
  assign w_tog_ext = {1'b0, q ^ tmask};

  always_comb begin
    w_next_ext = w_q_ext;
    w_ld       = 1'b0;
    w_wrap_set = 1'b0;
    w_err_set  = 1'b0;
    if (load) begin
      if (w_din_ext <= LP_MAX) begin
        w_next_ext = w_din_ext;
        w_ld       = 1'b1;
      end else begin
        w_err_set = 1'b1;
      end
    end else if (en) begin
      case (mode)
        MODE_TOGGLE: begin
          if (w_tog_ext <= LP_MAX) begin
            w_next_ext = w_tog_ext;
          end else begin
            w_err_set = 1'b1;
          end
        end
        MODE_UP: begin
          if (w_q_ext < LP_MAX) begin
            w_next_ext = w_q_ext + LP_ONE;
          end else if (!SATURATE) begin
            w_next_ext = '0;
            w_wrap_set = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (w_q_ext != '0) begin
            w_next_ext = w_q_ext - LP_ONE;
          end else if (!SATURATE) begin
            w_next_ext = LP_MAX;
            w_wrap_set = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The register only ever moves by flipping the bits that differ from the target value.
  assign w_t_vec  = q ^ w_next_ext[WIDTH-1:0];
  assign w_unused = w_next_ext[WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    t_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .t       (w_t_vec[gi]),
      .ld      (w_ld),
      .d       (din[gi]),
      .rst_val (LP_RST[gi]),
      .q       (q[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_set;
      r_err  <= w_err_set;
    end
  end

  assign wrap   = r_wrap;
  assign err    = r_err;
  assign at_max = (w_q_ext == LP_MAX);
  assign at_min = (q == '0);

endmodule

// File: tb/tb_t_ff_counter.sv
// tb/tb_t_ff_counter.sv - directed self-checking bench for t_ff_counter (wrap and saturate builds)
module tb_t_ff_counter;
  import t_ff_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         r;
    logic         l;
    logic         e;
    logic [1:0]   m;
    logic [W-1:0] tm;
    logic [W-1:0] d;
    logic [7:0]   ew;
    logic [7:0]   es;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = MODE_HOLD;
  logic [W-1:0] tmask = '0;
  logic [W-1:0] din = '0;

  logic [W-1:0] qw, qs;
  logic         maxw, minw, wrw, erw;
  logic         maxs, mins, wrs, ers;
  logic [7:0]   obs_w, obs_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  t_ff_counter #(.WIDTH(W), .MAX_VAL(9), .RST_VAL(3), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .tmask(tmask), .load(load), .din(din),
    .q(qw), .at_max(maxw), .at_min(minw), .wrap(wrw), .err(erw)
  );

  t_ff_counter #(.WIDTH(W), .MAX_VAL(9), .RST_VAL(3), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .tmask(tmask), .load(load), .din(din),
    .q(qs), .at_max(maxs), .at_min(mins), .wrap(wrs), .err(ers)
  );

  // Observation word: {q, at_max, at_min, wrap, err}
  assign obs_w = {qw, maxw, minw, wrw, erw};
  assign obs_s = {qs, maxs, mins, wrs, ers};

  function automatic vec_t mk(input logic r, input logic l, input logic e, input logic [1:0] m,
                              input logic [W-1:0] tm, input logic [W-1:0] d,
                              input logic [7:0] ew, input logic [7:0] es);
    vec_t v;
    v.r = r; v.l = l; v.e = e; v.m = m; v.tm = tm; v.d = d; v.ew = ew; v.es = es;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.r; load = v.l; en = v.e; mode = v.m; tmask = v.tm; din = v.d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      apply(mk((k < 2) ? 1'b0 : 1'b1, 1'b0, 1'b0, MODE_HOLD, 4'd0, 4'd0, {4'd3, 4'b0000}, {4'd3, 4'b0000}));
      checks++;
      if (obs_w !== {4'd3, 4'b0000}) begin
        errors++;
        $display("FAIL reset_hold[%0d] wrap_dut: got q=%0d flags=%b exp q=3 flags=0000", k, obs_w[7:4], obs_w[3:0]);
      end
      checks++;
      if (obs_s !== {4'd3, 4'b0000}) begin
        errors++;
        $display("FAIL reset_hold[%0d] sat_dut: got q=%0d flags=%b exp q=3 flags=0000", k, obs_s[7:4], obs_s[3:0]);
      end
    end
  endtask

  task automatic test_up_wrap();
    vec_t v[4];
    v[0] = mk(1'b1, 1'b1, 1'b0, MODE_HOLD, 4'd0, 4'd8, {4'd8, 4'b0000}, {4'd8, 4'b0000});
    v[1] = mk(1'b1, 1'b0, 1'b1, MODE_UP,   4'd0, 4'd0, {4'd9, 4'b1000}, {4'd9, 4'b1000});
    v[2] = mk(1'b1, 1'b0, 1'b1, MODE_UP,   4'd0, 4'd0, {4'd0, 4'b0110}, {4'd9, 4'b1000});
    v[3] = mk(1'b1, 1'b0, 1'b1, MODE_UP,   4'd0, 4'd0, {4'd1, 4'b0000}, {4'd9, 4'b1000});
    foreach (v[k]) begin
      apply(v[k]);
      checks++;
      if (obs_w !== v[k].ew) begin
        errors++;
        $display("FAIL up_wrap[%0d] wrap_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_w[7:4], obs_w[3:0], v[k].ew[7:4], v[k].ew[3:0]);
      end
      checks++;
      if (obs_s !== v[k].es) begin
        errors++;
        $display("FAIL up_wrap[%0d] sat_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_s[7:4], obs_s[3:0], v[k].es[7:4], v[k].es[3:0]);
      end
    end
  endtask

  task automatic test_down_saturate();
    vec_t v[4];
    v[0] = mk(1'b1, 1'b1, 1'b0, MODE_HOLD, 4'd0, 4'd1, {4'd1, 4'b0000}, {4'd1, 4'b0000});
    v[1] = mk(1'b1, 1'b0, 1'b1, MODE_DOWN, 4'd0, 4'd0, {4'd0, 4'b0100}, {4'd0, 4'b0100});
    v[2] = mk(1'b1, 1'b0, 1'b1, MODE_DOWN, 4'd0, 4'd0, {4'd9, 4'b1010}, {4'd0, 4'b0100});
    v[3] = mk(1'b1, 1'b0, 1'b1, MODE_DOWN, 4'd0, 4'd0, {4'd8, 4'b0000}, {4'd0, 4'b0100});
    foreach (v[k]) begin
      apply(v[k]);
      checks++;
      if (obs_w !== v[k].ew) begin
        errors++;
        $display("FAIL down_sat[%0d] wrap_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_w[7:4], obs_w[3:0], v[k].ew[7:4], v[k].ew[3:0]);
      end
      checks++;
      if (obs_s !== v[k].es) begin
        errors++;
        $display("FAIL down_sat[%0d] sat_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_s[7:4], obs_s[3:0], v[k].es[7:4], v[k].es[3:0]);
      end
    end
  endtask

  task automatic test_toggle_range();
    vec_t v[5];
    v[0] = mk(1'b1, 1'b1, 1'b0, MODE_HOLD,   4'd0,    4'd3, {4'd3, 4'b0000}, {4'd3, 4'b0000});
    v[1] = mk(1'b1, 1'b0, 1'b1, MODE_TOGGLE, 4'b0101, 4'd0, {4'd6, 4'b0000}, {4'd6, 4'b0000});
    v[2] = mk(1'b1, 1'b0, 1'b1, MODE_TOGGLE, 4'b1000, 4'd0, {4'd6, 4'b0001}, {4'd6, 4'b0001});
    v[3] = mk(1'b1, 1'b0, 1'b1, MODE_TOGGLE, 4'b0000, 4'd0, {4'd6, 4'b0000}, {4'd6, 4'b0000});
    v[4] = mk(1'b1, 1'b0, 1'b0, MODE_TOGGLE, 4'b1111, 4'd0, {4'd6, 4'b0000}, {4'd6, 4'b0000});
    foreach (v[k]) begin
      apply(v[k]);
      checks++;
      if (obs_w !== v[k].ew) begin
        errors++;
        $display("FAIL toggle[%0d] wrap_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_w[7:4], obs_w[3:0], v[k].ew[7:4], v[k].ew[3:0]);
      end
      checks++;
      if (obs_s !== v[k].es) begin
        errors++;
        $display("FAIL toggle[%0d] sat_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_s[7:4], obs_s[3:0], v[k].es[7:4], v[k].es[3:0]);
      end
    end
  endtask

  task automatic test_load_priority();
    vec_t v[3];
    v[0] = mk(1'b1, 1'b1, 1'b1, MODE_UP, 4'd0, 4'd12, {4'd6, 4'b0001}, {4'd6, 4'b0001});
    v[1] = mk(1'b1, 1'b1, 1'b1, MODE_UP, 4'd0, 4'd7,  {4'd7, 4'b0000}, {4'd7, 4'b0000});
    v[2] = mk(1'b1, 1'b1, 1'b0, MODE_UP, 4'd0, 4'd9,  {4'd9, 4'b1000}, {4'd9, 4'b1000});
    foreach (v[k]) begin
      apply(v[k]);
      checks++;
      if (obs_w !== v[k].ew) begin
        errors++;
        $display("FAIL load[%0d] wrap_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_w[7:4], obs_w[3:0], v[k].ew[7:4], v[k].ew[3:0]);
      end
      checks++;
      if (obs_s !== v[k].es) begin
        errors++;
        $display("FAIL load[%0d] sat_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_s[7:4], obs_s[3:0], v[k].es[7:4], v[k].es[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    vec_t v[4];
    v[0] = mk(1'b1, 1'b1, 1'b0, MODE_HOLD, 4'd0, 4'd8, {4'd8, 4'b0000}, {4'd8, 4'b0000});
    v[1] = mk(1'b1, 1'b0, 1'b1, MODE_UP,   4'd0, 4'd0, {4'd9, 4'b1000}, {4'd9, 4'b1000});
    v[2] = mk(1'b0, 1'b0, 1'b1, MODE_UP,   4'd0, 4'd0, {4'd3, 4'b0000}, {4'd3, 4'b0000});
    v[3] = mk(1'b1, 1'b0, 1'b1, MODE_UP,   4'd0, 4'd0, {4'd4, 4'b0000}, {4'd4, 4'b0000});
    foreach (v[k]) begin
      apply(v[k]);
      checks++;
      if (obs_w !== v[k].ew) begin
        errors++;
        $display("FAIL rst_mid[%0d] wrap_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_w[7:4], obs_w[3:0], v[k].ew[7:4], v[k].ew[3:0]);
      end
      checks++;
      if (obs_s !== v[k].es) begin
        errors++;
        $display("FAIL rst_mid[%0d] sat_dut: got q=%0d flags=%b exp q=%0d flags=%b", k, obs_s[7:4], obs_s[3:0], v[k].es[7:4], v[k].es[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_saturate();
    test_toggle_range();
    test_load_priority();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
